// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// req_lock exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
) ();

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
`ifdef UART_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [IDX_W-1:0]          grant_id;
  logic                      arb_active;
  logic                      tx_err;

  modport master (
    input  req_valid,
    input  req_data,
    output req_ready,
`ifdef UART_ARB_LOCK_EN
    input  req_lock,
`endif
    output tx_start,
    output tx_data,
    input  tx_busy,
    output grant_id,
    output arb_active,
    output tx_err
  );

  modport slave (
    output req_valid,
    output req_data,
    input  req_ready,
`ifdef UART_ARB_LOCK_EN
    output req_lock,
`endif
    input  tx_start,
    input  tx_data,
    output tx_busy,
    input  grant_id,
    input  arb_active,
    input  tx_err
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first valid index after i_last, with wrap.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = IDX_W'((int'(i_last) + k) % NUM_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_LOCK_EN to let the last winner hold the grant via req_lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = UART_DATA_W,
  parameter int BUSY_WAIT_MAX = 15
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.master bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_WAIT_MAX - 1);

  arb_state_t        r_state;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_gid;
  logic [DATA_W-1:0] r_data;
  logic              r_start;
  logic              r_err;
  logic [CW-1:0]     r_cnt;

  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_rr_idx;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic               w_take;
  logic [DATA_W-1:0]  w_data;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt),
    .o_idx  (w_rr_idx),
    .o_any  (w_any)
  );

`ifdef UART_ARB_LOCK_EN
  logic r_lock_ok;
  logic w_lock_hit;

  // A locked, still-valid previous winner beats the rotation.
  assign w_lock_hit = r_lock_ok
                    & bus.req_lock[r_last]
                    & bus.req_valid[r_last];

  always_comb begin
    w_gnt = w_rr_gnt;
    w_idx = w_rr_idx;
    if (w_lock_hit) begin
      w_gnt         = '0;
      w_gnt[r_last] = 1'b1;
      w_idx         = r_last;
    end
  end
`else
  assign w_gnt = w_rr_gnt;
  assign w_idx = w_rr_idx;
`endif

  assign w_take = (r_state == S_IDLE) & ~rst
                & ~bus.tx_busy & w_any;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_gid   <= '0;
      r_data  <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
`ifdef UART_ARB_LOCK_EN
      r_lock_ok <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_data  <= w_data;
            r_gid   <= w_idx;
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_last  <= r_gid;
            r_state <= S_IDLE;
`ifdef UART_ARB_LOCK_EN
            r_lock_ok <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_last  <= r_gid;
            r_state <= S_IDLE;
`ifdef UART_ARB_LOCK_EN
            r_lock_ok <= 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_take ? w_gnt : '0;
  assign bus.tx_start   = r_start;
  assign bus.tx_data    = r_data;
  assign bus.grant_id   = r_gid;
  assign bus.arb_active = (r_state != S_IDLE);
  assign bus.tx_err     = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter model.
// Lock scenario runs when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_W        (DW),
    .BUSY_WAIT_MAX (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic m_busy   = 1'b0;
  logic ext_busy = 1'b0;
  logic xmit_en  = 1'b1;
  logic abort    = 1'b0;

  assign bus.tx_busy = m_busy | ext_busy;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic wait_start(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.tx_start && k < 60);
    if (!bus.tx_start) begin
      n_chk++;
      $display("FAIL %s: tx_start got 0 expected 1 within 60 cycles", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((bus.arb_active || bus.tx_busy) && k < 100);
    if (bus.arb_active || bus.tx_busy) begin
      n_chk++;
      $display("FAIL %s: arb_active got 1 expected 0 within 100 cycles", nm);
    end
  endtask

  task automatic wait_sb(input int left, input string nm);
    int k = 0;
    while (sb.size() > left && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() > left) begin
      n_chk++;
      $display("FAIL %s: pending got %0d expected %0d", nm, sb.size(), left);
    end
  endtask

  // Transmitter: busy 2 cycles after start, for 4 cycles.
  initial begin
    logic [7:0] cap;
    forever begin
      @(negedge clk);
      if (bus.tx_start && xmit_en) begin
        cap = bus.tx_data;
        repeat (2) @(posedge clk);
        #1 m_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (!abort) chk("tx_data_hold", 32'(bus.tx_data), 32'(cap));
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.tx_start) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_tx_start: got grant %0d expected none",
                 bus.grant_id);
      end else begin
        m_e = sb.pop_front();
        chk("grant_id", 32'(bus.grant_id), 32'(m_e.id));
        chk("tx_data", 32'(bus.tx_data), 32'(m_e.d));
      end
    end
    if (!rst && bus.req_ready != '0) begin
      chk("ready_onehot_idle",
          32'({bus.arb_active, $onehot(bus.req_ready)}), 32'h1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 4'($urandom);
    bus.req_data  = $urandom;
    ext_busy      = 1'($urandom);
`ifdef UART_ARB_LOCK_EN
    bus.req_lock  = 4'($urandom);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
    chk("rst_arb_active", 32'(bus.arb_active), 32'h0);
    chk("rst_tx_err", 32'(bus.tx_err), 32'h0);

    @(posedge clk);
    #1;
    rst           = 1'b0;
    ext_busy      = 1'b0;
    bus.req_valid = 4'h0;
    bus.req_data  = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
`ifdef UART_ARB_LOCK_EN
    bus.req_lock  = 4'h0;
`endif

    // Fairness: all valid from reset
    push(2'd0, 8'h3C); push(2'd1, 8'h5A);
    push(2'd2, 8'hA5); push(2'd3, 8'hC3);
    push(2'd0, 8'h3C); push(2'd1, 8'h5A);
    push(2'd2, 8'hA5); push(2'd3, 8'hC3);
    @(posedge clk);
    #1 bus.req_valid = 4'hF;
    wait_sb(0, "fair_done");
    #1 bus.req_valid = 4'h0;
    wait_idle("fair_idle");

    // Single grant to requester 2
    @(posedge clk);
    #1;
    push(2'd2, 8'hA5);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_req_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    chk("single_start_lat", 32'(bus.tx_start), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 4'h0;
    wait_idle("single_idle");

    // Timeout: transmitter never goes busy
    @(posedge clk);
    #1;
    xmit_en = 1'b0;
    push(2'd3, 8'hC3);
    bus.req_valid = 4'hF;
    wait_start("to_start");
    @(posedge clk);
    #1 bus.req_valid = 4'h0;
    repeat (15) @(negedge clk);
    chk("to_err_early", 32'(bus.tx_err), 32'h0);
    @(negedge clk);
    chk("to_err_pulse", 32'(bus.tx_err), 32'h1);
    chk("to_idle", 32'(bus.arb_active), 32'h0);
    @(negedge clk);
    chk("to_err_single", 32'(bus.tx_err), 32'h0);
    @(posedge clk);
    #1;
    xmit_en = 1'b1;
    push(2'd0, 8'h3C);
    bus.req_valid = 4'hF;
    wait_start("to_next_start");
    @(posedge clk);
    #1 bus.req_valid = 4'h0;
    wait_idle("to_next_idle");

    // External busy blocks grants in IDLE
    @(posedge clk);
    #1;
    ext_busy      = 1'b1;
    bus.req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ext_busy_ready", 32'(bus.req_ready), 32'h0);
      chk("ext_busy_active", 32'(bus.arb_active), 32'h0);
    end
    @(posedge clk);
    #1;
    push(2'd1, 8'h5A);
    ext_busy = 1'b0;
    wait_start("ext_start");
    @(posedge clk);
    #1 bus.req_valid = 4'h0;
    wait_idle("ext_idle");

    // Reset during WAIT_DONE
    @(posedge clk);
    #1;
    push(2'd2, 8'hA5);
    bus.req_valid = 4'hF;
    wait_start("mid_start");
    @(posedge clk);
    #1 bus.req_valid = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_in_done", 32'({bus.arb_active, bus.tx_busy}), 32'h3);
    abort = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_active", 32'(bus.arb_active), 32'h0);
    chk("mid_rst_gid", 32'(bus.grant_id), 32'h0);
    chk("mid_rst_data", 32'(bus.tx_data), 32'h0);
    chk("mid_rst_start", 32'(bus.tx_start), 32'h0);
    repeat (10) @(negedge clk);
    wait_idle("mid_idle");
    abort = 1'b0;

    // Rotation resumes at 0 after reset
    @(posedge clk);
    #1;
    push(2'd0, 8'h3C);
    bus.req_valid = 4'hF;
    wait_start("post_rst_start");
    @(posedge clk);
    #1 bus.req_valid = 4'h0;
    wait_idle("post_rst_idle");

`ifdef UART_ARB_LOCK_EN
    @(posedge clk);
    #1;
    push(2'd1, 8'h5A); push(2'd1, 8'h5A);
    push(2'd1, 8'h5A); push(2'd2, 8'hA5);
    bus.req_lock  = 4'b0010;
    bus.req_valid = 4'hF;
    wait_sb(1, "lock_three");
    #1 bus.req_lock = 4'h0;
    wait_sb(0, "lock_release");
    #1 bus.req_valid = 4'h0;
    wait_idle("lock_idle");
`endif

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: pending got %0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
